tdm_frame_mixer: RTL
====================

// Module: tdm_frame_mixer
// PURPOSE
//  Parametrised end-of-pipeline mixer for the TDM voice stream. Accumulates one signed
//  sample per voice slot per frame and normalises the frame sum by a selectable mode.
//  Emits one mixed sample per frame with a valid strobe, for the DAC/PWM output stage.
//  Adds frame-sync checking, gap tolerance (tdm_valid), active-voice counting and saturation.
// PARAMETERS
//  D_W        16  sample width, signed two's complement, in and out
//  NUM_VOICES  4  voice slots per frame, >=2
//  VOICE_BITS  2  clog2(NUM_VOICES), channel number width
//  RECIP_W    16  fractional bits of reciprocal used in MODE_AVG
// PORTS
//  sys_clk        in   1             system clock, all logic on rising edge
//  sys_rst_n      in   1             asynchronous active-low reset
//  tdm_valid      in   1             slot present this cycle; low = bubble, state held
//  tdm_chan_num   in   VOICE_BITS    voice slot index of the current sample
//  tdm_chan_en    in   1             voice enabled; disabled slot contributes 0, not counted
//  tdm_data_in    in   D_W           signed voice sample
//  norm_mode      in   2             0 SHIFT (sum>>>VOICE_BITS), 1 AVG (sum/active), 2 SAT (sum clipped), 3 = 0
//  mix_out        out  D_W           signed mixed sample, held between frames
//  mix_valid      out  1             one-cycle strobe when mix_out updates
//  active_count   out  VOICE_BITS+1  enabled voices in last completed frame
//  frame_err      out  1             one-cycle strobe on slot-order violation
// BEHAVIOUR
//  - Reset: mix_out=0, mix_valid=0, active_count=0, frame_err=0, accumulator=0, count=0,
//    expected slot=0, sync state=HUNT. Reset mid-frame discards the partial frame.
//  - ACC_W = D_W+VOICE_BITS signed accumulator; no internal overflow possible.
//  - Sync FSM: HUNT -> LOCK on valid with chan_num==0. In LOCK every valid sample must carry
//    chan_num==expected; expected increments, wraps NUM_VOICES-1 -> 0.
//  - Mismatch in LOCK: frame_err=1 next cycle, partial frame dropped, no mix_valid.
//    If the offending sample is chan 0 it starts a new frame (stay LOCK), else go HUNT.
//  - Accumulate: chan 0 loads acc=(en?data:0), cnt=en; other slots add. tdm_valid=0 holds all.
//  - Frame complete: valid sample chan NUM_VOICES-1 accepted in LOCK at cycle t;
//    norm_mode sampled at t. t+1: final sum and count latched into normalise stage.
//    t+2: mix_out, active_count updated, mix_valid=1 for exactly that cycle. Latency 2.
//  - Next frame's chan 0 may arrive at t+1 (back-to-back); the pipeline never stalls.
//  - SHIFT: arithmetic shift right by VOICE_BITS, truncate to D_W (legacy behaviour).
//  - AVG: sum * round(2^RECIP_W/cnt), add 2^(RECIP_W-1), arithmetic >>>RECIP_W, saturate.
//    cnt==0 -> mix_out=0 (mix_valid still pulses).
//  - SAT: sum clipped to [-2^(D_W-1), 2^(D_W-1)-1].
//  - frame_err and mix_valid never assert in the same cycle for the same frame.
// STRUCTURE
//  - tdm_defs.vh: NORM_SHIFT/NORM_AVG/NORM_SAT codes, HUNT/LOCK encodings, ACC_W macro.
//  - Sub-module tdm_recip_rom: cnt -> reciprocal constant, generated for 1..NUM_VOICES,
//    pure lookup, infers LUTs (or one DSP multiply in the parent).
//  - Parent holds sync FSM, accumulator stage, normalise/saturate output stage.
// TESTING
//  1. SHIFT, all en, slots 0..3 = 1000,2000,3000,4000 -> 2 cycles after slot 3: mix_out=2500,
//     mix_valid 1 cycle, active_count=4.
//  2. AVG, en only slots 1,3 = 1000,3000 -> mix_out=2000, active_count=2.
//  3. SAT, 4x 30000 -> 32767; 4x -20000 -> -32768; AVG, no voices enabled -> 0.
//  4. Slots 0,2 (slot 1 skipped) -> frame_err pulse, no mix_valid; next clean frame mixes correctly.
//  5. Bubbles: tdm_valid low 3 cycles between slots 1 and 2 -> same result as test 1.
//     Back-to-back frames -> one mix_valid every 4 cycles.
//  6. sys_rst_n low after slot 2, release, full frame of 100s in SAT -> mix_out=400,
//     no stale contribution; all outputs 0 during reset.

Source files
------------

// File: rtl/tdm_frame_mixer_pkg.sv
// Shared types and helpers for the TDM frame mixer: normalisation modes,
// sync FSM states and the reciprocal constant used by averaging.
package tdm_frame_mixer_pkg;

  typedef enum logic [1:0] {
    NORM_SHIFT = 2'd0,
    NORM_AVG   = 2'd1,
    NORM_SAT   = 2'd2,
    NORM_ZERO  = 2'd3
  } norm_mode_e;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } sync_state_e;

  // round(2^frac_w / cnt); only ever evaluated for cnt >= 1
  function automatic int unsigned recip_round(input int unsigned cnt, input int unsigned frac_w);
    return ((32'd1 << frac_w) + (cnt / 32'd2)) / cnt;
  endfunction

endpackage

// File: rtl/tdm_recip_rom.sv
// Active-voice count to fixed-point reciprocal lookup; zero for an empty frame.
module tdm_recip_rom
  import tdm_frame_mixer_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VOICE_BITS = 2,
  parameter int unsigned RECIP_W    = 16
) (
  input  logic [VOICE_BITS:0] cnt,
  output logic [RECIP_W:0]    recip_c
);

  always_comb begin
    recip_c = '0;
    for (int unsigned i = 1; i <= NUM_VOICES; i++) begin
      if (cnt == (VOICE_BITS + 1)'(i)) recip_c = (RECIP_W + 1)'(recip_round(i, RECIP_W));
    end
  end

endmodule

// File: rtl/tdm_frame_mixer.sv
// End-of-pipeline TDM voice mixer: slot-order sync, per-frame accumulation and a
// two-stage normalise/saturate output with a one-cycle valid strobe.
module tdm_frame_mixer
  import tdm_frame_mixer_pkg::*;
#(
  parameter int unsigned D_W        = 16,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VOICE_BITS = 2,
  parameter int unsigned RECIP_W    = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        tdm_valid,
  input  logic [VOICE_BITS-1:0]       tdm_chan_num,
  input  logic                        tdm_chan_en,
  input  logic signed [D_W-1:0]       tdm_data_in,
  input  logic [1:0]                  norm_mode,
  output logic signed [D_W-1:0]       mix_out,
  output logic                        mix_valid,
  output logic [VOICE_BITS:0]         active_count,
  output logic                        frame_err
);

  localparam int unsigned ACC_W  = D_W + VOICE_BITS;
  localparam int unsigned CNT_W  = VOICE_BITS + 1;
  localparam int unsigned PROD_W = ACC_W + RECIP_W + 2;
  localparam logic [VOICE_BITS-1:0] LAST_CH = VOICE_BITS'(NUM_VOICES - 1);
  localparam logic signed [PROD_W-1:0] ROUND_K = PROD_W'(1) << (RECIP_W - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

  sync_state_e               state, state_nxt;
  logic [VOICE_BITS-1:0]     expected;
  logic signed [ACC_W-1:0]   acc, contrib_c, sum_c;
  logic [CNT_W-1:0]          cnt, cnt_sum_c;
  logic                      in_order_c, is_first_c;
  logic                      take_c, load_c, done_c, err_c;

  logic                      fin_valid;
  logic signed [ACC_W-1:0]   fin_sum;
  logic [CNT_W-1:0]          fin_cnt;
  norm_mode_e                fin_mode;

  logic [RECIP_W:0]          recip_c;
  logic signed [PROD_W-1:0]  prod_c, avg_c;
  logic signed [D_W-1:0]     norm_c;

  function automatic logic signed [D_W-1:0] sat_d(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[D_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[D_W-1:0];
    return v[D_W-1:0];
  endfunction

  assign in_order_c = (tdm_chan_num == expected);
  assign is_first_c = (tdm_chan_num == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= HUNT;
    else            state <= state_nxt;
  end

  // A chan-0 sample always (re)starts a frame; any other out-of-order slot drops sync
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (tdm_valid && is_first_c) state_nxt = LOCK;
      LOCK: if (tdm_valid && !in_order_c && !is_first_c) state_nxt = HUNT;
    endcase
  end

  always_comb begin
    take_c = 1'b0;
    err_c  = 1'b0;
    load_c = 1'b0;
    done_c = 1'b0;
    case (state)
      HUNT: take_c = tdm_valid && is_first_c;
      LOCK: begin
        take_c = tdm_valid && (in_order_c || is_first_c);
        err_c  = tdm_valid && !in_order_c;
      end
    endcase
    load_c = take_c && is_first_c;
    done_c = take_c && (tdm_chan_num == LAST_CH);
  end

  always_comb begin
    contrib_c = tdm_chan_en ? ACC_W'(tdm_data_in) : '0;
    sum_c     = load_c ? contrib_c : acc + contrib_c;
    cnt_sum_c = (load_c ? '0 : cnt) + CNT_W'(tdm_chan_en);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      expected <= '0;
    end else if (take_c) begin
      acc      <= sum_c;
      cnt      <= cnt_sum_c;
      expected <= (tdm_chan_num == LAST_CH) ? '0 : tdm_chan_num + VOICE_BITS'(1);
    end
  end

  // Completed frame handed to the normalise stage together with its mode
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fin_valid <= 1'b0;
      fin_sum   <= '0;
      fin_cnt   <= '0;
      fin_mode  <= NORM_SHIFT;
      frame_err <= 1'b0;
    end else begin
      fin_valid <= done_c;
      frame_err <= err_c;
      if (done_c) begin
        fin_sum  <= sum_c;
        fin_cnt  <= cnt_sum_c;
        fin_mode <= norm_mode_e'(norm_mode);
      end
    end
  end

  tdm_recip_rom #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_BITS (VOICE_BITS),
    .RECIP_W    (RECIP_W)
  ) u_recip_rom (
    .cnt     (fin_cnt),
    .recip_c (recip_c)
  );

  always_comb begin
    prod_c = PROD_W'(fin_sum) * $signed(PROD_W'(recip_c));
    avg_c  = (prod_c + ROUND_K) >>> RECIP_W;
    norm_c = '0;
    case (fin_mode)
      NORM_SHIFT: norm_c = D_W'(fin_sum >>> VOICE_BITS);
      NORM_AVG:   if (fin_cnt != '0) norm_c = sat_d(avg_c);
      NORM_SAT:   norm_c = sat_d(PROD_W'(fin_sum));
      default:    norm_c = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      active_count <= '0;
    end else begin
      mix_valid <= fin_valid;
      if (fin_valid) begin
        mix_out      <= norm_c;
        active_count <= fin_cnt;
      end
    end
  end

endmodule
